led_cube_scanner: RTL and testbench
===================================

LED_CUBE_SCANNER -- requirements
Module: led_cube_scanner

Interface
REQ-001 Parameter: LAYER_HOLD, default 1024, minimum display clk cycles per layer.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 enable  input  1  high = scanning; low = blank cube, return to IDLE.
REQ-005 data_to_latch  input  8  frame byte from the stream buffer, combinationally addressed by frame_addr.
REQ-006 frame_addr  output  6  registered read address into the current frame (layer*8 + row).
REQ-007 sr_data  output  1  serial data to the chained 64-bit column shift registers.
REQ-008 sr_clk  output  1  shift clock; registers sample sr_data on its rising edge.
REQ-009 sr_latch  output  1  storage-register latch pulse.
REQ-010 sr_oe_n  output  1  column output enable, active-low.
REQ-011 layer_sel  output  8  one-hot layer driver; all-zero = no layer on.
REQ-012 frame_done  output  1  one-cycle pulse when layer 7 display ends and layer 0 swaps in.

Function
REQ-013 States: IDLE, PRELOAD, SCAN, BLANK, LATCH.
- Shifter sub-FSM inside PRELOAD/SCAN: ADDR, BIT_LO, BIT_HI.
REQ-014 Byte read:
- ADDR cycle drives frame_addr = layer*8 + row.
- data_to_latch is captured on the following cycle: one-cycle read latency.
REQ-015 Each bit takes 2 cycles:
- BIT_LO: sr_clk=0, sr_data=bit.
- BIT_HI: sr_clk=1, sr_data held.
- Bits are sent MSB first.
REQ-016 Each layer sends rows 0..7 in order: 8*(1+16) = 136 cycles.
- shift_done is set on completion and held until the swap.
REQ-017 IDLE -> PRELOAD when enable=1.
- PRELOAD shifts layer 0 with sr_oe_n=1 and layer_sel=0, then goes to BLANK.
REQ-018 SCAN:
- Displays the current layer while shifting the next layer (wrap 7->0).
- hold_cnt counts up from 0.
REQ-019 SCAN -> BLANK when hold_cnt >= LAYER_HOLD-1 AND shift_done.
- If LAYER_HOLD < 137, the swap is paced by shift_done alone.
REQ-020 BLANK (1 cycle): sr_oe_n=1, layer_sel=0.
REQ-021 LATCH (1 cycle): sr_latch=1.
REQ-022 Entering SCAN after LATCH:
- layer_sel = one-hot(new layer), sr_oe_n=0.
- hold_cnt=0, shift_done=0.
- Shifting of the following layer starts in the same cycle.
REQ-023 frame_done=1 in the cycle SCAN is entered with layer 0, except the first entry after PRELOAD.
REQ-024 Layer index is 3 bits and wraps 7->0 by natural overflow.
- row and bit counters are 3 bits.
- hold_cnt is wide enough for LAYER_HOLD and saturates.
REQ-025 enable=0 in any state: the next cycle is IDLE with all outputs at reset values and all counters cleared.
- Any partial shift is abandoned.
REQ-026 Outside BLANK/LATCH/SCAN, sr_latch=0.
- layer_sel never has more than one bit set.
- layer_sel is never nonzero while sr_oe_n=1.

Reset
REQ-027 When rst=1 (takes priority over enable), the next edge sets:
- frame_addr=0, sr_data=0, sr_clk=0, sr_latch=0, sr_oe_n=1, layer_sel=0, frame_done=0.
- State IDLE, all counters 0.
REQ-028 rst asserted mid-shift or mid-display blanks the cube on the next edge.
- No sr_latch pulse is emitted.

Structure
REQ-029 Package led_cube_pkg holds:
- scanner state enum and shifter state enum.
- LAYERS=8, ROWS=8, BYTES_PER_FRAME=64, BITS_PER_LAYER=64.
REQ-030 Sub-module led_cube_shifter:
- Takes start and layer; drives frame_addr, sr_data and sr_clk; raises done after 136 cycles.
- The top level holds the scan FSM, hold counter and layer drivers.

Verification
REQ-031 Reset then enable=1, frame byte 0 = 8'hA5:
- frame_addr=0 on cycle 1.
- sr_data = 1,0,1,0,0,1,0,1 on the eight sr_clk rising edges.
REQ-032 LAYER_HOLD=200, full frame of bytes = address:
- layer_sel steps 01,02,...,80,01.
- Period is 203 cycles per layer: 200 SCAN + BLANK + LATCH + 1.
- frame_done pulses once per 8 layers.
REQ-033 LAYER_HOLD=16:
- Layer period = 136 + 2 cycles.
- No swap occurs before shift_done.
REQ-034 Check sequence at every swap:
- Cycle 1: sr_oe_n=1 and layer_sel=0.
- Cycle 2: one sr_latch pulse.
- Cycle 3: sr_oe_n=0 and new layer_sel.
REQ-035 enable drop mid-byte (bit 3 of row 5):
- Next cycle: IDLE, sr_oe_n=1, layer_sel=0, sr_clk=0.
- Re-enable restarts PRELOAD at layer 0, row 0.
REQ-036 rst=1 during SCAN of layer 4: all outputs at reset values next cycle; no sr_latch pulse.

Source files
------------

// File: rtl/led_cube_pkg.sv
// Shared types and geometry for the 8x8x8 LED cube scanner.
package led_cube_pkg;

  localparam int LAYERS          = 8;
  localparam int ROWS            = 8;
  localparam int BYTES_PER_FRAME = 64;
  localparam int BITS_PER_LAYER  = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_SCAN,
    ST_BLANK,
    ST_LATCH
  } scan_state_t;

  typedef enum logic [1:0] {
    SH_IDLE,
    SH_ADDR,
    SH_BIT_LO,
    SH_BIT_HI
  } shift_state_t;

  // One-hot layer driver pattern for a 3-bit layer index.
  function automatic logic [7:0] layer_onehot(input logic [2:0] layer);
    return 8'd1 << layer;
  endfunction

endpackage

// File: rtl/led_cube_scanner_if.sv
// Frame-buffer read port plus column shift-register and layer driver bus.
// There is no valid/ready handshake on this bus: enable is a level (high =
// scan, low = blank and idle), data_to_latch is a combinational read of the
// address on frame_addr, and every scanner output is a registered level.
interface led_cube_scanner_if;
  import led_cube_pkg::*;

  logic                                enable;
  logic [7:0]                          data_to_latch;
  logic [$clog2(BYTES_PER_FRAME)-1:0]  frame_addr;
  logic                                sr_data;
  logic                                sr_clk;
  logic                                sr_latch;
  logic                                sr_oe_n;
  logic [LAYERS-1:0]                   layer_sel;
  logic                                frame_done;

  modport master (
    input  enable, data_to_latch,
    output frame_addr, sr_data, sr_clk, sr_latch, sr_oe_n, layer_sel, frame_done
  );

  modport slave (
    output enable, data_to_latch,
    input  frame_addr, sr_data, sr_clk, sr_latch, sr_oe_n, layer_sel, frame_done
  );

endinterface

// File: rtl/led_cube_shifter.sv
// Serialises one layer (8 rows x 8 bits, MSB first) into the column shift
// registers. Each row costs one address cycle plus two cycles per bit, so a
// layer takes 136 cycles. done rises together with the final sr_clk high.
module led_cube_shifter
  import led_cube_pkg::*;
(
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_start,
  input  logic [2:0]   i_layer,
  input  logic [7:0]   i_data,
  output logic [5:0]   o_frame_addr,
  output logic         o_sr_data,
  output logic         o_sr_clk,
  output logic         o_done,
  output shift_state_t o_state
);

  shift_state_t r_state;
  logic [2:0]   r_layer;
  logic [2:0]   r_row;
  logic [2:0]   r_bit;
  logic [7:0]   r_byte;
  logic [5:0]   r_frame_addr;
  logic         r_sr_data;
  logic         r_sr_clk;
  logic         r_done;
  logic [2:0]   w_next_row;

  assign w_next_row   = r_row + 3'd1;
  assign o_frame_addr = r_frame_addr;
  assign o_sr_data    = r_sr_data;
  assign o_sr_clk     = r_sr_clk;
  assign o_done       = r_done;
  assign o_state      = r_state;

  // Shifter sequencer: address a row, then clock its bits out MSB first.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_state      <= SH_IDLE;
      r_layer      <= 3'd0;
      r_row        <= 3'd0;
      r_bit        <= 3'd0;
      r_byte       <= 8'd0;
      r_frame_addr <= 6'd0;
      r_sr_data    <= 1'b0;
      r_sr_clk     <= 1'b0;
      r_done       <= 1'b0;
    end else if (i_start) begin
      r_state      <= SH_ADDR;
      r_layer      <= i_layer;
      r_row        <= 3'd0;
      r_bit        <= 3'd0;
      r_frame_addr <= {i_layer, 3'd0};
      r_sr_clk     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        SH_ADDR: begin
          // The byte addressed last cycle is valid now.
          r_byte    <= i_data;
          r_sr_data <= i_data[7];
          r_bit     <= 3'd0;
          r_state   <= SH_BIT_LO;
        end
        SH_BIT_LO: begin
          r_sr_clk <= 1'b1;
          r_state  <= SH_BIT_HI;
          if (r_row == 3'd7 && r_bit == 3'd7) r_done <= 1'b1;
        end
        SH_BIT_HI: begin
          r_sr_clk <= 1'b0;
          if (r_bit == 3'd7) begin
            if (r_row == 3'd7) begin
              r_state <= SH_IDLE;
            end else begin
              r_row        <= w_next_row;
              r_frame_addr <= {r_layer, w_next_row};
              r_state      <= SH_ADDR;
            end
          end else begin
            r_bit     <= r_bit + 3'd1;
            r_byte    <= {r_byte[6:0], 1'b0};
            r_sr_data <= r_byte[6];
            r_state   <= SH_BIT_LO;
          end
        end
        default: r_state <= SH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/led_cube_scanner.sv
// LED cube scanner: preloads layer 0, then displays each layer while the next
// one is shifted in, swapping through a one-cycle blank and a latch pulse.
module led_cube_scanner
  import led_cube_pkg::*;
#(
  parameter int LAYER_HOLD = 1024
)(
  input  logic                clk,
  input  logic                rst,
  led_cube_scanner_if.master  bus,
  output scan_state_t         o_dbg_state,
  output shift_state_t        o_dbg_shift_state
);

  localparam int              HW       = $clog2(LAYER_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(LAYER_HOLD - 1);

  scan_state_t   r_state;
  logic [2:0]    r_layer;      // layer currently in (or entering) the shift registers
  logic          r_first;      // first SCAN entry after PRELOAD suppresses frame_done
  logic [HW-1:0] r_hold_cnt;
  logic          r_hold_ok;    // registered hold expiry, costs one SCAN cycle
  logic          r_sr_latch;
  logic          r_sr_oe_n;
  logic [7:0]    r_layer_sel;
  logic          r_frame_done;

  logic          w_clear;
  logic          w_start;
  logic          w_sh_done;
  logic [2:0]    w_sh_layer;
  logic [5:0]    w_frame_addr;
  logic          w_sr_data;
  logic          w_sr_clk;

  assign w_clear    = rst || !bus.enable;
  assign w_start    = !w_clear && (r_state == ST_IDLE || r_state == ST_LATCH);
  assign w_sh_layer = (r_state == ST_LATCH) ? r_layer + 3'd1 : 3'd0;

  led_cube_shifter u_shifter (
    .clk          (clk),
    .i_clear      (w_clear),
    .i_start      (w_start),
    .i_layer      (w_sh_layer),
    .i_data       (bus.data_to_latch),
    .o_frame_addr (w_frame_addr),
    .o_sr_data    (w_sr_data),
    .o_sr_clk     (w_sr_clk),
    .o_done       (w_sh_done),
    .o_state      (o_dbg_shift_state)
  );

  assign bus.frame_addr = w_frame_addr;
  assign bus.sr_data    = w_sr_data;
  assign bus.sr_clk     = w_sr_clk;
  assign bus.sr_latch   = r_sr_latch;
  assign bus.sr_oe_n    = r_sr_oe_n;
  assign bus.layer_sel  = r_layer_sel;
  assign bus.frame_done = r_frame_done;
  assign o_dbg_state    = r_state;

  // Scan FSM with registered blanking, latch and layer-driver outputs.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state      <= ST_IDLE;
      r_layer      <= 3'd0;
      r_first      <= 1'b0;
      r_hold_cnt   <= '0;
      r_hold_ok    <= 1'b0;
      r_sr_latch   <= 1'b0;
      r_sr_oe_n    <= 1'b1;
      r_layer_sel  <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_PRELOAD;
          r_layer <= 3'd0;
          r_first <= 1'b1;
        end
        ST_PRELOAD: begin
          if (w_sh_done) r_state <= ST_BLANK;
        end
        ST_SCAN: begin
          if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + 1'b1;
          r_hold_ok <= (r_hold_cnt >= HOLD_MAX);
          if (r_hold_ok && w_sh_done) begin
            r_state     <= ST_BLANK;
            r_sr_oe_n   <= 1'b1;
            r_layer_sel <= 8'd0;
          end
        end
        ST_BLANK: begin
          r_state    <= ST_LATCH;
          r_sr_latch <= 1'b1;
        end
        ST_LATCH: begin
          r_state      <= ST_SCAN;
          r_sr_latch   <= 1'b0;
          r_sr_oe_n    <= 1'b0;
          r_layer_sel  <= layer_onehot(r_layer);
          r_hold_cnt   <= '0;
          r_hold_ok    <= 1'b0;
          r_frame_done <= (r_layer == 3'd0) && !r_first;
          r_first      <= 1'b0;
          r_layer      <= r_layer + 3'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_cube_scanner.sv
// Bench for led_cube_scanner: a long-hold and a short-hold instance checked
// cycle by cycle against a timeline/bitstream model of the scan sequence.
module tb_led_cube_scanner;
  import led_cube_pkg::*;

  localparam int HOLD_L     = 200;
  localparam int HOLD_S     = 16;
  localparam int SHIFT_CYC  = 8 * (1 + 16);   // cycles to shift one layer
  localparam int FIRST_SCAN = SHIFT_CYC + 3;  // PRELOAD, BLANK, LATCH, then SCAN
  localparam logic [18:0] RESET_WORD = {6'd0, 4'b0001, 8'd0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en_l;
  logic en_s;
  logic use_short;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs and frame memory ----------------
  logic [7:0] mem [64];

  led_cube_scanner_if if_l ();
  led_cube_scanner_if if_s ();

  assign if_l.enable        = en_l;
  assign if_s.enable        = en_s;
  assign if_l.data_to_latch = mem[if_l.frame_addr];
  assign if_s.data_to_latch = mem[if_s.frame_addr];

  scan_state_t  dbg_l, dbg_s;
  shift_state_t dsh_l, dsh_s;

  led_cube_scanner #(.LAYER_HOLD(HOLD_L)) u_dut_l (
    .clk               (clk),
    .rst               (rst),
    .bus               (if_l),
    .o_dbg_state       (dbg_l),
    .o_dbg_shift_state (dsh_l)
  );

  led_cube_scanner #(.LAYER_HOLD(HOLD_S)) u_dut_s (
    .clk               (clk),
    .rst               (rst),
    .bus               (if_s),
    .o_dbg_state       (dbg_s),
    .o_dbg_shift_state (dsh_s)
  );

  logic [18:0] ob_all_l, ob_all_s, ob_all;
  assign ob_all_l = {if_l.frame_addr, if_l.sr_data, if_l.sr_clk, if_l.sr_latch,
                     if_l.sr_oe_n, if_l.layer_sel, if_l.frame_done};
  assign ob_all_s = {if_s.frame_addr, if_s.sr_data, if_s.sr_clk, if_s.sr_latch,
                     if_s.sr_oe_n, if_s.layer_sel, if_s.frame_done};
  assign ob_all   = use_short ? ob_all_s : ob_all_l;

  logic [5:0]  ob_addr;
  logic        ob_sr_data, ob_sr_clk, ob_latch, ob_fd;
  logic [10:0] ob_outs;
  assign ob_addr    = ob_all[18:13];
  assign ob_sr_data = ob_all[12];
  assign ob_sr_clk  = ob_all[11];
  assign ob_latch   = ob_all[10];
  assign ob_fd      = ob_all[0];
  assign ob_outs    = {ob_all[9], ob_all[8:1], ob_all[10], ob_all[0]};

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A displayed layer stays on for the longer of the shift time and hold+1
  // cycles, followed by one blank cycle and one latch cycle.
  function automatic int scan_len(input int hold);
    return (hold + 1 > SHIFT_CYC) ? hold + 1 : SHIFT_CYC;
  endfunction

  // Expected {sr_oe_n, layer_sel, sr_latch, frame_done} c cycles after enable.
  function automatic logic [10:0] exp_outs(input int c, input int hold);
    int per, k, ph;
    logic oe_n, lat, fd;
    logic [7:0] sel;
    per = scan_len(hold) + 2;
    oe_n = 1'b1; sel = 8'd0; lat = 1'b0; fd = 1'b0;
    if (c == FIRST_SCAN - 1) begin
      lat = 1'b1;
    end else if (c >= FIRST_SCAN) begin
      k  = (c - FIRST_SCAN) / per;
      ph = (c - FIRST_SCAN) % per;
      if (ph < scan_len(hold)) begin
        oe_n = 1'b0;
        sel  = 8'd1 << (k % 8);
        fd   = (ph == 0) && (k > 0) && (k % 8 == 0);
      end else if (ph == scan_len(hold) + 1) begin
        lat = 1'b1;
      end
    end
    return {oe_n, sel, lat, fd};
  endfunction

  // Expected read address while a layer is being shifted, -1 otherwise.
  function automatic int exp_addr(input int c, input int hold);
    int per, k, ph;
    per = scan_len(hold) + 2;
    if (c >= 1 && c <= SHIFT_CYC) return (c - 1) / 17;
    if (c >= FIRST_SCAN) begin
      k  = (c - FIRST_SCAN) / per;
      ph = (c - FIRST_SCAN) % per;
      if (ph < SHIFT_CYC) return ((k + 1) % 8) * 8 + ph / 17;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  // Enable one DUT from IDLE and check it for ncycles cycles.
  task automatic run_scan(input bit short_dut, input int ncycles);
    int hold, per, ea, bits, lat_cnt, fd_cnt;
    logic prev_clk;
    logic [7:0] first_byte;
    hold = short_dut ? HOLD_S : HOLD_L;
    per  = scan_len(hold) + 2;
    use_short = short_dut;
    exp_q.delete();
    for (int l = 0; l < 16; l++)
      for (int r = 0; r < 8; r++)
        for (int b = 7; b >= 0; b--)
          exp_q.push_back(mem[(l % 8) * 8 + r][b]);
    if (short_dut) en_s = 1'b1; else en_l = 1'b1;
    prev_clk = 1'b0; bits = 0; lat_cnt = 0; fd_cnt = 0; first_byte = 8'd0;
    for (int c = 1; c <= ncycles; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("addr_cycle1", 32'(ob_addr), 32'(0));
      check("outs", 32'(ob_outs), 32'(exp_outs(c, hold)));
      ea = exp_addr(c, hold);
      if (ea >= 0) check("frame_addr", 32'(ob_addr), 32'(ea));
      if (ob_sr_clk && !prev_clk) begin
        if (exp_q.size() > 0) check("sr_data", 32'(ob_sr_data), 32'(exp_q.pop_front()));
        else check("exp_q_size", 32'(exp_q.size()), 32'(1));
        if (bits < 8) first_byte = {first_byte[6:0], ob_sr_data};
        bits++;
        if (bits == 8) check("first_byte", 32'(first_byte), 32'(mem[0]));
      end
      prev_clk = ob_sr_clk;
      if (ob_latch) begin
        check("bits_at_latch", 32'(bits), 32'(64 * (lat_cnt + 1)));
        lat_cnt++;
      end
      if (ob_fd) fd_cnt++;
    end
    if (ncycles >= FIRST_SCAN)
      check("frame_done_count", 32'(fd_cnt), 32'(((ncycles - FIRST_SCAN) / per) / 8));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    use_short = 1'b0;
    foreach (mem[i]) mem[i] = 8'(i);
    mem[0] = 8'hA5;

    // Reset wins over enable.
    rst = 1'b1; en_l = 1'b1; en_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_l", 32'(ob_all_l), 32'(RESET_WORD));
    check("reset_s", 32'(ob_all_s), 32'(RESET_WORD));
    check("reset_state_l", 32'(dbg_l), 32'(ST_IDLE));
    check("reset_state_s", 32'(dbg_s), 32'(ST_IDLE));
    rst = 1'b0; en_l = 1'b0; en_s = 1'b0;
    @(posedge clk); #1;

    // Long hold, bytes = address (byte 0 = A5): more than a full frame.
    run_scan(1'b0, FIRST_SCAN + 9 * (HOLD_L + 3) + 5);
    en_l = 1'b0;
    @(posedge clk); #1;
    check("idle_after_drop_l", 32'(ob_all_l), 32'(RESET_WORD));

    // Random frame, short hold: drop enable on bit 3 of row 5 (sr_clk high).
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
    run_scan(1'b1, 17 * 5 + 3 + 2 * 3);
    check("pre_drop_clk", 32'(ob_sr_clk), 32'(1));
    check("pre_drop_addr", 32'(ob_addr), 32'(5));
    en_s = 1'b0;
    @(posedge clk); #1;
    check("drop_outs", 32'(ob_all_s), 32'(RESET_WORD));
    check("drop_state", 32'(dbg_s), 32'(ST_IDLE));
    check("drop_shift_state", 32'(dsh_s), 32'(SH_IDLE));

    // Re-enable restarts from layer 0 row 0; run a random length.
    n = FIRST_SCAN + $urandom_range(0, 1300);
    run_scan(1'b1, n);
    en_s = 1'b0;
    @(posedge clk); #1;
    check("idle_after_drop_s", 32'(ob_all_s), 32'(RESET_WORD));

    // Reset while layer 4 is displayed on the long-hold instance.
    foreach (mem[i]) mem[i] = 8'($urandom_range(0, 255));
    run_scan(1'b0, FIRST_SCAN + 4 * (HOLD_L + 3) + $urandom_range(1, 150));
    check("layer4_shown", 32'(if_l.layer_sel), 32'(8'h10));
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_outs", 32'(ob_all_l), 32'(RESET_WORD));
    end
    check("rst_state", 32'(dbg_l), 32'(ST_IDLE));
    rst = 1'b0; en_l = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
